// File: rtl/tt_um_anthem_checker.sv
// Matches a received byte stream against a fixed 51-byte phrase ROM; results registered, latency 1, no stall.
// Define ANTHEM_CHECK_CASE_FOLD_EN to fold a-z onto A-Z before comparing.
module tt_um_anthem_checker #(
    parameter int PHRASE_LEN = 51
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int ROM_LEN = 51;
    localparam logic [ROM_LEN*8-1:0] ROM = "Tajumulco Tacana Acatenango Fuego Santa Maria Agua ";
    localparam logic [5:0] LEN = 6'(PHRASE_LEN);

    typedef enum logic [1:0] {HUNT, TRACK, DONE} state_t;

    state_t     state_q;
    logic [5:0] idx_q;
    logic       done_q;
    logic       err_q;
    logic [3:0] err_cnt_q;
    logic [3:0] pass_cnt_q;

    logic       clear;
    logic       accept;
    logic [7:0] rx;
    logic       hit_first;
    logic       hit_idx;
    logic [5:0] next_idx;
    state_t     hunt_state_d;
    logic [5:0] hunt_idx_d;
    logic       hunt_done_d;
    logic       unused_uio;

    // Addresses past the ROM return zero so no out-of-range part-select is ever formed.
    function automatic logic [7:0] rom_at(input logic [5:0] i);
        logic [ROM_LEN*8-1:0] sh;
        sh = ROM << {i, 3'b000};
        return (i < 6'(ROM_LEN)) ? sh[ROM_LEN*8-1 -: 8] : 8'h00;
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef ANTHEM_CHECK_CASE_FOLD_EN
        return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
`else
        return b;
`endif
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : (c + 4'h1);
    endfunction

    assign clear      = ena & uio_in[1];
    assign accept     = ena & uio_in[0] & ~uio_in[1];
    assign unused_uio = &{1'b0, uio_in[7:2]};

    // HUNT, DONE and a TRACK mismatch all restart from the same first-byte evaluation.
    always_comb begin
        rx           = fold(ui_in);
        hit_first    = (rx == fold(rom_at(6'd0)));
        hit_idx      = (rx == fold(rom_at(idx_q)));
        next_idx     = idx_q + 6'd1;
        hunt_idx_d   = hit_first ? 6'd1 : 6'd0;
        hunt_done_d  = hit_first && (LEN == 6'd1);
        hunt_state_d = HUNT;
        if (hit_first) begin
            hunt_state_d = (LEN == 6'd1) ? DONE : TRACK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            idx_q      <= 6'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 4'd0;
            pass_cnt_q <= 4'd0;
        end else if (clear) begin
            state_q    <= HUNT;
            idx_q      <= 6'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 4'd0;
            pass_cnt_q <= 4'd0;
        end else if (accept) begin
            case (state_q)
                TRACK: begin
                    if (hit_idx) begin
                        idx_q <= next_idx;
                        if (next_idx == LEN) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            pass_cnt_q <= sat_inc(pass_cnt_q);
                        end
                    end else begin
                        state_q   <= hunt_state_d;
                        idx_q     <= hunt_idx_d;
                        done_q    <= hunt_done_d;
                        err_q     <= 1'b1;
                        err_cnt_q <= sat_inc(err_cnt_q);
                        if (hunt_done_d) begin
                            pass_cnt_q <= sat_inc(pass_cnt_q);
                        end
                    end
                end
                default: begin
                    state_q <= hunt_state_d;
                    idx_q   <= hunt_idx_d;
                    done_q  <= hunt_done_d;
                    if (hunt_done_d) begin
                        pass_cnt_q <= sat_inc(pass_cnt_q);
                    end
                end
            endcase
        end
    end

    assign uo_out  = {err_q, done_q, idx_q};
    assign uio_out = {err_cnt_q, pass_cnt_q};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_anthem_checker.sv
module tb_tt_um_anthem_checker;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       probe;

    int tests;
    int fails;

    typedef struct packed {
        logic       chk;
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    string phr_s = "Tajumulco Tacana Acatenango Fuego Santa Maria Agua ";

    tt_um_anthem_checker #(.PHRASE_LEN(51)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ph(input int i);
        return phr_s[i];
    endfunction

    function automatic logic [7:0] flip(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) return b ^ 8'h20;
        return b;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic void push(input bit chk, input logic [7:0] uo, input logic [7:0] uio, input string nm);
        exp_q.push_back('{chk: chk, uo: uo, uio: uio});
        name_q.push_back(nm);
    endfunction

    // Monitor: every cycle the DUT consumes an input (or the driver asks for a probe) yields one scoreboard entry.
    always @(posedge clk) begin
        logic act;
        exp_t e;
        string nm;
        act = (rst_n && ena && (uio_in[0] || uio_in[1])) || probe;
        #1;
        if (act) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.chk) check(nm, {uo_out, uio_out}, {e.uo, e.uio});
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit chk, input logic [7:0] uo, input logic [7:0] uio, input string nm);
        @(negedge clk);
        ena = 1'b1; uio_in = 8'h01; ui_in = b; probe = 1'b0;
        push(chk, uo, uio, nm);
    endtask

    task automatic clear_cmd(input string nm);
        @(negedge clk);
        ena = 1'b1; uio_in = 8'h03; ui_in = 8'h54; probe = 1'b0;
        push(1'b1, 8'h00, 8'h00, nm);
    endtask

    task automatic idle();
        @(negedge clk);
        uio_in = 8'h00; probe = 1'b0;
    endtask

    task automatic do_probe(input logic [7:0] uo, input logic [7:0] uio, input string nm);
        @(negedge clk);
        uio_in = 8'h00; probe = 1'b1;
        push(1'b1, uo, uio, nm);
    endtask

    initial begin
        #400000;
        fails++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00; probe = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        do_probe(8'h00, 8'h00, "reset_state");
        check("uio_oe", {8'h00, uio_oe}, 16'h00FF);

        // Full phrase, back to back.
        for (int i = 0; i < 51; i++)
            send(ph(i), 1'b1, (i == 50) ? 8'h73 : 8'(i + 1), (i == 50) ? 8'h01 : 8'h00, "full_phrase");

        // "Taju" then 'X': error, then 'T' resyncs to index 1.
        send("T", 1'b1, 8'h01, 8'h01, "taju_T");
        send("a", 1'b1, 8'h02, 8'h01, "taju_a");
        send("j", 1'b1, 8'h03, 8'h01, "taju_j");
        send("u", 1'b1, 8'h04, 8'h01, "taju_u");
        send(8'h58, 1'b1, 8'h80, 8'h11, "mismatch_X");
        send("T", 1'b1, 8'h81, 8'h11, "after_err_T");

        // "Taj" then 'T': same-cycle resync, then finish the phrase.
        send("a", 1'b1, 8'h82, 8'h11, "taj_a");
        send("j", 1'b1, 8'h83, 8'h11, "taj_j");
        send("T", 1'b1, 8'h81, 8'h21, "resync_T");
        for (int i = 1; i < 51; i++)
            send(ph(i), 1'b1, (i == 50) ? 8'hF3 : (8'h80 | 8'(i + 1)), (i == 50) ? 8'h22 : 8'h21, "resync_phrase");
        idle();

        // Clear mid-phrase, then async reset mid-phrase.
        clear_cmd("clear_after_done");
        for (int i = 0; i < 20; i++)
            send(ph(i), i == 19, 8'h14, 8'h00, "index_20");
        clear_cmd("clear_mid_phrase");
        for (int i = 0; i < 20; i++)
            send(ph(i), i == 19, 8'h14, 8'h00, "index_20_again");
        @(negedge clk);
        uio_in = 8'h00;
        #2 rst_n = 1'b0;
        #1 check("async_reset", {uo_out, uio_out}, 16'h0000);
        do_probe(8'h00, 8'h00, "in_reset");
        @(negedge clk);
        probe = 1'b0; rst_n = 1'b1;
        ena = 1'b1; uio_in = 8'h01; ui_in = ph(0);
        push(1'b1, 8'h01, 8'h00, "first_edge_after_reset");
        for (int i = 1; i < 51; i++)
            send(ph(i), i == 50, 8'h73, 8'h01, "phrase_after_reset");

        // Error counter saturation.
        for (int k = 1; k <= 17; k++) begin
            send("T", 1'b0, 8'h00, 8'h00, "sat_err_T");
            send(8'h58, 1'b1, 8'h80, {((k > 15) ? 4'hF : 4'(k)), 4'h1}, "err_count");
        end
        // Pass counter saturation.
        for (int p = 1; p <= 16; p++)
            for (int i = 0; i < 51; i++)
                send(ph(i), i == 50, 8'hF3, {4'hF, ((p + 1 > 15) ? 4'hF : 4'(p + 1))}, "pass_count");

        // ena low: valid and clear ignored.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ena = 1'b0; uio_in = (c % 3 == 2) ? 8'h03 : 8'h01; ui_in = 8'(c * 7 + 3); probe = 1'b1;
            push(1'b1, 8'hF3, 8'hFF, "ena_hold");
        end
        idle();

        clear_cmd("clear_before_case");
`ifdef ANTHEM_CHECK_CASE_FOLD_EN
        for (int i = 0; i < 51; i++)
            send(flip(ph(i)), 1'b1, (i == 50) ? 8'h73 : 8'(i + 1), (i == 50) ? 8'h01 : 8'h00, "case_fold");
`else
        send("t", 1'b1, 8'h00, 8'h00, "lower_t_hunt");
        send("T", 1'b1, 8'h01, 8'h00, "upper_T");
        send(flip(ph(1)), 1'b1, 8'h80, 8'h10, "upper_A_err");
`endif
        idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drain", 16'(exp_q.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tt_um_anthem_checker.md
TT_UM_ANTHEM_CHECKER -- requirements
Module: tt_um_anthem_checker

Interface
REQ-001 SHALL have parameter PHRASE_LEN, default 51, the number of phrase bytes checked (1..51).
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ena  input  1  design enable; while low, no byte is accepted and all state holds.
REQ-005 SHALL have port ui_in  input  8  received ASCII data byte.
REQ-006 SHALL have port uio_in  input  8  bit0 = valid strobe, bit1 = synchronous clear, bits7:2 ignored.
REQ-007 SHALL have port uo_out  output  8  bits5:0 = match index, bit6 = done, bit7 = error flag.
REQ-008 SHALL have port uio_out  output  8  bits7:4 = error count, bits3:0 = pass count (each saturating at 15).
REQ-009 SHALL have port uio_oe  output  8  constant 8'hFF when PHRASE_LEN valid; bits3:0 and 7:4 always driven.

Function
REQ-010 SHALL hold a fixed 51-byte phrase ROM: "Tajumulco Tacana Acatenango Fuego Santa Maria Agua " (0x54 ... 0x20, byte 50 = 0x20).
REQ-011 SHALL accept a byte on a rising clk edge when ena=1, uio_in[0]=1 and uio_in[1]=0.
REQ-012 SHALL implement states HUNT, TRACK, DONE; reset state HUNT.
REQ-013 HUNT: accepted byte == ROM[0] -> index=1, state TRACK (or DONE if PHRASE_LEN=1); else stay HUNT, no error counted.
REQ-014 TRACK: accepted byte == ROM[index] -> index+1; when index+1 == PHRASE_LEN -> state DONE, pass count +1.
REQ-015 TRACK mismatch: error count +1, error flag set, index=0, state HUNT; if the mismatching byte == ROM[0] then index=1, state TRACK instead (same-cycle resync).
REQ-016 DONE: done=1, index holds PHRASE_LEN; next accepted byte evaluated exactly as in HUNT (REQ-013), clearing done.
REQ-017 Error flag SHALL be sticky until clear or reset; counters SHALL saturate at 15, never wrap.
REQ-018 All outputs SHALL be registered; effect of an accepted byte visible on outputs the cycle after acceptance (latency 1).
REQ-019 Clear (uio_in[1]=1 with ena=1) SHALL take priority over valid: state HUNT, index 0, flags and both counters 0.
REQ-020 Index SHALL never exceed PHRASE_LEN; ROM reads at index >= 51 SHALL not occur.
REQ-021 Back-to-back accepted bytes (valid high every cycle) SHALL be checked at one byte per cycle with no stall.

Reset
REQ-022 On rst_n low, asynchronously: state HUNT, uo_out=8'h00, uio_out=8'h00, all counters and flags 0.
REQ-023 Reset asserted mid-phrase SHALL abandon the partial match; after release, checking restarts in HUNT.
REQ-024 First byte accepted SHALL be on the first rising clk edge after rst_n deasserts.

Configuration
REQ-025 Macro ANTHEM_CHECK_CASE_FOLD_EN SHALL select comparison mode.
REQ-026 Defined: both received byte and ROM byte fold 0x61..0x7A to 0x41..0x5A before compare; "tAJU" matches "Taju".
REQ-027 Undefined: exact 8-bit compare; 't' (0x74) does not match 'T' (0x54).

Verification
REQ-028 Reset, then stream all 51 ROM bytes with valid=1 every cycle -> cycle after last byte: uo_out=8'h73 (done, index 51), uio_out=8'h01.
REQ-029 Stream "Taju" then 0x58 -> uo_out[7]=1, index 0, uio_out[7:4]=1; then "T" -> index 1, state TRACK.
REQ-030 Stream "Taj" then 0x54 -> error count 1, index 1 (resync), full phrase from byte 1 onward then reaches done.
REQ-031 Mid-phrase (index 20) assert clear with valid=1 -> next cycle uo_out=8'h00, uio_out=8'h00; also assert rst_n low at index 20 -> outputs 0 immediately.
REQ-032 Send 17 mismatching phrases -> error count reads 15 (saturated); 16 complete phrases -> pass count 15.
REQ-033 Hold ena=0 with valid=1 and changing data for 10 cycles -> outputs unchanged; with macro defined, lowercase phrase -> done, undefined -> error after byte 0 'T' vs 't' stays HUNT.
